store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Write buffer between the MEM-stage control signals and the 256x32 word-addressed data memory.
- Stores are queued in a small FIFO and drained into memory on cycles when no load needs the single memory port.
- Loads are served the same cycle, either from the youngest matching buffered store or from memory.
- Goal: loads never wait behind stores; the CPU stalls only when the buffer is full.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, >=2)
- AW, 32, byte-address width
- DW, 32, data width (full-word stores only)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- cpu_addr  in  AW  byte address from EX/MEM
- cpu_wdata  in  DW  store data
- cpu_mem_write  in  1  store request this cycle
- cpu_mem_read  in  1  load request this cycle
- cpu_rdata  out  DW  load result, combinational, same cycle
- stall  out  1  store cannot be accepted; CPU holds EX/MEM
- empty  out  1  no buffered stores (used for halt/fence)
- mem_addr  out  AW  byte address to data memory (memory divides by 4)
- mem_wdata  out  DW  write data to data memory
- mem_write  out  1  write enable to data memory
- mem_rdata  in  DW  asynchronous read data from data memory

Behaviour:
- State:
  - Circular FIFO of DEPTH entries {word_addr = addr[AW-1:2], data}.
  - Head and tail pointers, each log2(DEPTH) bits, wrap naturally.
  - count, 0..DEPTH.
- Reset (rst_n=0 at a clock edge):
  - count, head and tail go to 0.
  - Buffered entries are discarded, including mid-drain; no memory write occurs.
  - Outputs while and after reset: empty=1, stall=0, mem_write=0.
- Memory port arbitration, combinational, priority order:
  1. cpu_mem_read=1: mem_addr=cpu_addr, mem_write=0. The load owns the port and nothing drains.
  2. Else if count>0: mem_addr={head.word_addr,2'b00}, mem_wdata=head.data, mem_write=1. Head pops at the clock edge.
  3. Else: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_write=0.
- Load data, combinational:
  - Search all valid entries for word_addr==cpu_addr[AW-1:2].
  - If any match, cpu_rdata = data of the youngest match (closest to tail).
  - If no match, cpu_rdata = mem_rdata.
  - Comparison uses the full word address, not the 8-bit memory index.
- Push:
  - stall = cpu_mem_write & (count==DEPTH). Stall does not depend on a same-cycle pop, so there is no combinational path from the read port.
  - When cpu_mem_write & !stall, {cpu_addr[AW-1:2], cpu_wdata} is written at tail at the edge; tail increments.
- Count update per edge: push only +1; pop only -1; push and pop together, unchanged.
- Latency: a store pushed at edge N is drained at edge N+1 at the earliest, provided cycle N+1 has no load.
- Simultaneous cpu_mem_read and cpu_mem_write:
  - The load is served from the buffer as it stood before this cycle's store, then memory.
  - The store is pushed if not full. No drain occurs that cycle.
- Full and empty boundaries:
  - Count never exceeds DEPTH and never underflows; a pop happens only when count>0.
  - empty = (count==0), registered-state derived.
- Sustained loads starve the drain indefinitely. This is accepted; stall bounds buffer growth.
- cpu_addr[1:0] are ignored for stores and loads (word accesses only).

Test Plan:
1. rst_n=0 for 2 cycles with cpu_mem_write=1 → empty=1, stall=0, mem_write=0; no entry queued after release.
2. Store 0x10←0xDEADBEEF, then idle → next cycle mem_write=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; the cycle after, empty=1, mem_write=0.
3. Continuous loads from 0x40 (mem_rdata=0x55) while storing 0x0,0x4,0x8,0xC,0x14 → cpu_rdata=0x55 throughout, mem_write=0. stall=1 on the 5th store. Drop the read one cycle → mem_write=1, mem_addr=0x0; the 5th store is accepted the following cycle.
4. Store 0x20←0x1, store 0x20←0x2, then load 0x20 with mem_rdata=0x99 → cpu_rdata=0x2. Load 0x24 → cpu_rdata=0x99.
5. Buffer holds 0x30←0x7. In the same cycle, load 0x30 and store 0x30←0x8 → cpu_rdata=0x7, count becomes 2. Next load 0x30 → 0x8.
6. Three entries buffered, rst_n=0 for one cycle during drain → empty=1 next cycle, no further mem_write pulses, memory contents for the undrained addresses unchanged.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and a single-port data memory: stores queue in a
// circular FIFO and drain on load-free cycles; loads forward from the youngest match.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_mem_write,
    input  logic          cpu_mem_read,
    output logic [DW-1:0] cpu_rdata,
    output logic          stall,
    output logic          empty,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [AW-3:0] word_addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t [DEPTH-1:0]        fifo;
    logic   [PW-1:0]           head, tail;
    logic   [CW-1:0]           count;
    logic                      full, push, pop;
    logic   [DEPTH-1:0]        hit;
    logic   [DEPTH-1:0][PW-1:0] age_idx;

    // Full is judged on the registered count only, so stall never sees the read port.
    assign full      = (count == CW'(DEPTH));
    assign push      = cpu_mem_write & ~full;
    assign pop       = ~cpu_mem_read & (count != '0);
    assign stall     = rst_n & cpu_mem_write & full;
    assign empty     = ~rst_n | (count == '0);
    assign mem_write = rst_n & pop;

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (pop) begin
            mem_addr  = {fifo[head].word_addr, 2'b00};
            mem_wdata = fifo[head].data;
        end
    end

    // Entries are examined by age: age 0 is the head (oldest), age count-1 the youngest.
    genvar g;
    for (g = 0; g < DEPTH; g++) begin : g_age
        assign age_idx[g] = head + PW'(g);
        assign hit[g]     = (CW'(g) < count) &&
                            (fifo[age_idx[g]].word_addr == cpu_addr[AW-1:2]);
    end

    always_comb begin
        cpu_rdata = mem_rdata;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit[i]) cpu_rdata = fifo[age_idx[i]].data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) fifo[tail] <= {cpu_addr[AW-1:2], cpu_wdata};
    end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, reset-during-drain memory check, and
// randomized traffic against a queue-based reference model with a modelled data memory.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, cpu_mem_write, cpu_mem_read;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        stall, empty, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem     [256];
    logic [31:0] exp_mem [256];

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr[9:2]];

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_mem_write(cpu_mem_write), .cpu_mem_read(cpu_mem_read), .cpu_rdata(cpu_rdata),
        .stall(stall), .empty(empty), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        r, rd, wr;
        logic [31:0] a, wd;
        logic        st, em, mw;
        logic [31:0] ma, mwd, rdt;
        logic        cma, crd;
    } vec_t;

    typedef struct {
        logic [29:0] wa;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    vec_t tbl[$];
    int   n_cmp = 0, n_err = 0, n_step = 0;

    function automatic vec_t mk(input logic r, rd, wr, input logic [31:0] a, wd,
                                input logic st, em, mw, input logic [31:0] ma, mwd, rdt,
                                input logic cma, crd);
        vec_t v;
        v.r = r; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd;
        v.st = st; v.em = em; v.mw = mw; v.ma = ma; v.mwd = mwd; v.rdt = rdt;
        v.cma = cma; v.crd = crd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got 0x%h expected 0x%h", nm, n_step, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict from the queue model, compare, advance.
    task automatic step(input vec_t v, input bit use_tbl);
        vec_t        m, e;
        logic        we;
        logic [7:0]  wi;
        logic [31:0] wdat;
        @(negedge clk);
        n_step++;
        rst_n = v.r; cpu_mem_read = v.rd; cpu_mem_write = v.wr;
        cpu_addr = v.a; cpu_wdata = v.wd;
        m = v;
        m.st = 1'b0; m.em = 1'b1; m.mw = 1'b0; m.cma = 1'b0; m.crd = 1'b0;
        m.ma = v.a; m.mwd = '0; m.rdt = '0;
        if (v.r) begin
            m.st  = v.wr && (q.size() == DEPTH);
            m.em  = (q.size() == 0);
            m.cma = 1'b1;
            if (v.rd) begin
                m.crd = 1'b1;
                m.rdt = exp_mem[v.a[9:2]];
                foreach (q[i]) if (q[i].wa == v.a[31:2]) m.rdt = q[i].d;
            end else if (q.size() > 0) begin
                m.mw  = 1'b1;
                m.ma  = {q[0].wa, 2'b00};
                m.mwd = q[0].d;
            end
        end
        e = use_tbl ? v : m;
        #2;
        chk("stall", 32'(stall), 32'(e.st));
        chk("empty", 32'(empty), 32'(e.em));
        chk("mem_write", 32'(mem_write), 32'(e.mw));
        if (e.cma) chk("mem_addr", mem_addr, e.ma);
        if (e.mw)  chk("mem_wdata", mem_wdata, e.mwd);
        if (e.crd) chk("cpu_rdata", cpu_rdata, e.rdt);
        we = mem_write; wi = mem_addr[9:2]; wdat = mem_wdata;
        if (!v.r) q.delete();
        else begin
            if (m.mw) begin
                exp_mem[q[0].wa[7:0]] = q[0].d;
                void'(q.pop_front());
            end
            if (v.wr && !m.st) q.push_back('{wa: v.a[31:2], d: v.wd});
        end
        @(posedge clk);
        if (we) mem[wi] = wdat;
    endtask

    initial begin
        logic [31:0] sa [4];
        logic [31:0] da [4];
        int rp;
        vec_t v;
        rst_n = 1'b0; cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < 256; i++) begin mem[i] = '0; exp_mem[i] = '0; end
        mem[16] = 32'h55; mem[8] = 32'h99; mem[9] = 32'h99;
        exp_mem[16] = 32'h55; exp_mem[8] = 32'h99; exp_mem[9] = 32'h99;

        // reset held with a store request, then a single store drained the next cycle
        tbl.push_back(mk(0,0,1,'h10,'h1111,     0,1,0,0,0,0, 0,0));
        tbl.push_back(mk(0,0,1,'h10,'h1111,     0,1,0,0,0,0, 0,0));
        tbl.push_back(mk(1,0,0,0,0,             0,1,0,0,0,0, 1,0));
        tbl.push_back(mk(1,0,1,'h10,'hDEADBEEF, 0,1,0,'h10,0,0, 1,0));
        tbl.push_back(mk(1,0,0,0,0,             0,0,1,'h10,'hDEADBEEF,0, 1,0));
        tbl.push_back(mk(1,0,0,0,0,             0,1,0,0,0,0, 1,0));
        // loads hold the port while the buffer fills
        sa[0] = 'h0; sa[1] = 'h4; sa[2] = 'h8; sa[3] = 'hC;
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(1,1,0,'h40,0,        0,(k==0),0,'h40,0,'h55, 1,1));
            tbl.push_back(mk(1,1,1,sa[k],'hA0+sa[k], 0,(k==0),0,sa[k],0,0, 1,1));
        end
        tbl.push_back(mk(1,1,0,'h40,0,          0,0,0,'h40,0,'h55, 1,1));
        tbl.push_back(mk(1,1,1,'h14,'hB4,       1,0,0,'h14,0,0, 1,1));
        tbl.push_back(mk(1,0,1,'h14,'hB4,       1,0,1,'h0,'hA0,0, 1,0));
        tbl.push_back(mk(1,1,1,'h14,'hB4,       0,0,0,'h14,0,0, 1,1));
        da[0] = 'h4; da[1] = 'h8; da[2] = 'hC; da[3] = 'h14;
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1,0,0,0,0,         0,0,1,da[k],'hA0+da[k],0, 1,0));
        tbl.push_back(mk(1,0,0,0,0,             0,1,0,0,0,0, 1,0));
        // youngest-match forwarding
        tbl.push_back(mk(1,1,1,'h20,'h1,        0,1,0,'h20,0,'h99, 1,1));
        tbl.push_back(mk(1,1,1,'h20,'h2,        0,0,0,'h20,0,'h1, 1,1));
        tbl.push_back(mk(1,1,0,'h20,0,          0,0,0,'h20,0,'h2, 1,1));
        tbl.push_back(mk(1,1,0,'h24,0,          0,0,0,'h24,0,'h99, 1,1));
        tbl.push_back(mk(1,0,0,0,0,             0,0,1,'h20,'h1,0, 1,0));
        tbl.push_back(mk(1,0,0,0,0,             0,0,1,'h20,'h2,0, 1,0));
        // load and store to the same word in one cycle
        tbl.push_back(mk(1,0,1,'h30,'h7,        0,1,0,'h30,0,0, 1,0));
        tbl.push_back(mk(1,1,1,'h30,'h8,        0,0,0,'h30,0,'h7, 1,1));
        tbl.push_back(mk(1,1,0,'h30,0,          0,0,0,'h30,0,'h8, 1,1));
        tbl.push_back(mk(1,0,0,0,0,             0,0,1,'h30,'h7,0, 1,0));
        tbl.push_back(mk(1,0,0,0,0,             0,0,1,'h30,'h8,0, 1,0));
        tbl.push_back(mk(1,0,0,0,0,             0,1,0,0,0,0, 1,0));
        // reset in the middle of a drain
        tbl.push_back(mk(1,1,1,'h50,'hC1,       0,1,0,'h50,0,0, 1,1));
        tbl.push_back(mk(1,1,1,'h54,'hC2,       0,0,0,'h54,0,0, 1,1));
        tbl.push_back(mk(1,1,1,'h58,'hC3,       0,0,0,'h58,0,0, 1,1));
        tbl.push_back(mk(1,0,0,0,0,             0,0,1,'h50,'hC1,0, 1,0));
        tbl.push_back(mk(0,0,0,0,0,             0,1,0,0,0,0, 0,0));
        tbl.push_back(mk(1,0,0,0,0,             0,1,0,0,0,0, 1,0));
        tbl.push_back(mk(1,0,0,0,0,             0,1,0,0,0,0, 1,0));

        foreach (tbl[i]) step(tbl[i], 1'b1);
        chk("rst_drain_mem50", mem[20], 32'hC1);
        chk("rst_drain_mem54", mem[21], 32'h0);
        chk("rst_drain_mem58", mem[22], 32'h0);

        // random traffic; aliased addresses (bit 12) share memory words but not buffer hits
        for (int k = 0; k < 3000; k++) begin
            rp = ((k / 200) % 2 == 1) ? 8 : 3;
            v = mk(($urandom_range(0, 63) != 0), ($urandom_range(0, 9) < rp),
                   ($urandom_range(0, 9) < 5),
                   ($urandom_range(0, 1) << 12) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3),
                   $urandom(), 0,0,0,0,0,0, 0,0);
            step(v, 1'b0);
        end
        for (int k = 0; k < DEPTH + 2; k++) step(mk(1,0,0,0,0, 0,0,0,0,0,0, 0,0), 1'b0);
        for (int i = 0; i < 256; i++) chk("mem_final", mem[i], exp_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
